// File: rtl/delay_line_bank_pkg.sv
// ============================================================================
// Module   : delay_line_bank_pkg
// Brief    : Access-FSM state encoding and width helpers for delay_line_bank.
// Revision : 1.0
// ============================================================================
`default_nettype none

package delay_line_bank_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEEK = 2'd1,
    ST_XFER = 2'd2,
    ST_DONE = 2'd3
  } dl_state_e;

  // Select/counter width that never collapses to zero bits.
  function automatic int clog2_min1(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

`default_nettype wire

// File: rtl/delay_line_bank_dl_line.sv
// ============================================================================
// Module   : dl_line
// Brief    : One recirculating LEN-cell serial line with head injection.
// Revision : 1.0
// ============================================================================
`default_nettype none

module dl_line #(
  parameter int LEN = 104
) (
  input  logic clk,
  input  logic rst,
  input  logic i_en,
  input  logic i_inj,
  input  logic i_inj_d,
  output logic o_tail
);

  logic [LEN-1:0] r_cells;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cells <= '0;
    end else if (i_en) begin
      r_cells <= {r_cells[LEN-2:0], (i_inj ? i_inj_d : r_cells[LEN-1])};
    end
  end

  assign o_tail = r_cells[LEN-1];

endmodule

`default_nettype wire

// File: rtl/delay_line_bank.sv
// ============================================================================
// Module   : delay_line_bank
// Brief    : Bank of recirculating delay lines with sense latches and a
//            word-parallel req/ack access port.
// Revision : 1.0
// ============================================================================
`default_nettype none

module delay_line_bank
  import delay_line_bank_pkg::*;
#(
  parameter int CHANNELS = 2,
  parameter int PHASES   = 4,
  parameter int WORD     = 26
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic                                  run,
  input  logic [CHANNELS-1:0]                   ser_we,
  input  logic [CHANNELS-1:0]                   ser_d,
  input  logic                                  req,
  input  logic                                  req_we,
  input  logic [clog2_min1(CHANNELS)-1:0]       req_ch,
  input  logic [clog2_min1(PHASES)-1:0]         req_reg,
  input  logic [WORD-1:0]                       req_wdata,
  output logic                                  busy,
  output logic                                  ack,
  output logic [WORD-1:0]                       rdata,
  output logic [CHANNELS*PHASES-1:0]            tap_q,
  output logic [clog2_min1(PHASES)-1:0]         phase,
  output logic [clog2_min1(WORD)-1:0]           bitidx
);

  localparam int LINE_LEN = PHASES * WORD;
  localparam int CW       = clog2_min1(CHANNELS);
  localparam int PW       = clog2_min1(PHASES);
  localparam int BW       = clog2_min1(WORD);

  logic [PW-1:0]             r_phase;
  logic [BW-1:0]             r_bitidx;
  logic [CHANNELS*PHASES-1:0] r_tap;

  dl_state_e                 r_state;
  logic [CW-1:0]             r_ch;
  logic [PW-1:0]             r_reg;
  logic                      r_we;
  logic [WORD-1:0]           r_wdata;
  logic [WORD-1:0]           r_sh;
  logic                      r_busy;
  logic                      r_ack;
  logic [WORD-1:0]           r_rdata;

  logic [CHANNELS-1:0]       w_tail;
  logic [CHANNELS-1:0]       w_fsm_inj;
  logic [CHANNELS-1:0]       w_inj;
  logic [CHANNELS-1:0]       w_inj_d;
  logic                      w_slot_hit;
  logic                      w_xfer;
  logic                      w_cap;
  logic                      w_wbit;
  logic [WORD-1:0]           w_sh_next;

  // Slot counters: phase is the fast digit, bitidx the slow one.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_phase  <= '0;
      r_bitidx <= '0;
    end else if (run) begin
      if (r_phase == PW'(PHASES - 1)) begin
        r_phase  <= '0;
        r_bitidx <= (r_bitidx == BW'(WORD - 1)) ? '0 : r_bitidx + 1'b1;
      end else begin
        r_phase <= r_phase + 1'b1;
      end
    end
  end

  assign w_slot_hit = run && (r_phase == r_reg);
  assign w_xfer     = ((r_state == ST_SEEK) && w_slot_hit && (r_bitidx == '0)) ||
                      ((r_state == ST_XFER) && w_slot_hit);
  assign w_cap      = w_tail[r_ch];
  assign w_wbit     = r_wdata[r_bitidx];

  always_comb begin
    w_sh_next           = r_sh;
    w_sh_next[r_bitidx] = w_cap;
  end

  generate
    for (genvar g = 0; g < CHANNELS; g++) begin : g_line
      // The access FSM owns the head cell whenever it writes this channel.
      assign w_fsm_inj[g] = w_xfer && r_we && (r_ch == CW'(g));
      assign w_inj[g]     = w_fsm_inj[g] || ser_we[g];
      assign w_inj_d[g]   = w_fsm_inj[g] ? w_wbit : ser_d[g];

      dl_line #(
        .LEN (LINE_LEN)
      ) u_line (
        .clk     (clk),
        .rst     (rst),
        .i_en    (run),
        .i_inj   (w_inj[g]),
        .i_inj_d (w_inj_d[g]),
        .o_tail  (w_tail[g])
      );
    end
  endgenerate

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_tap <= '0;
    end else if (run) begin
      for (int c = 0; c < CHANNELS; c++) begin
        for (int r = 0; r < PHASES; r++) begin
          if (r_phase == PW'(r)) begin
            r_tap[c*PHASES + r] <= w_tail[c];
          end
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_ch    <= '0;
      r_reg   <= '0;
      r_we    <= 1'b0;
      r_wdata <= '0;
      r_sh    <= '0;
      r_busy  <= 1'b0;
      r_ack   <= 1'b0;
      r_rdata <= '0;
    end else begin
      r_ack <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (req) begin
            r_ch    <= req_ch;
            r_reg   <= req_reg;
            r_we    <= req_we;
            r_wdata <= req_wdata;
            r_busy  <= 1'b1;
            r_state <= ST_SEEK;
          end
        end
        ST_SEEK: begin
          if (w_xfer) begin
            r_sh    <= w_sh_next;
            r_state <= ST_XFER;
          end
        end
        ST_XFER: begin
          if (w_xfer) begin
            r_sh <= w_sh_next;
            // Result is published together with ack so it includes the last bit.
            if (r_bitidx == BW'(WORD - 1)) begin
              r_state <= ST_DONE;
              r_ack   <= 1'b1;
              r_rdata <= w_sh_next;
            end
          end
        end
        ST_DONE: begin
          r_busy  <= 1'b0;
          r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign busy   = r_busy;
  assign ack    = r_ack;
  assign rdata  = r_rdata;
  assign tap_q  = r_tap;
  assign phase  = r_phase;
  assign bitidx = r_bitidx;

endmodule

`default_nettype wire

// File: tb/tb_delay_line_bank.sv
// ============================================================================
// Module   : tb_delay_line_bank
// Brief    : Directed self-checking bench for delay_line_bank (2 x 4 x 8).
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_delay_line_bank;

  localparam int CH  = 2;
  localparam int PH  = 4;
  localparam int WD  = 8;
  localparam int LEN = PH * WD;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       run = 1'b0;
  logic [1:0] ser_we = '0;
  logic [1:0] ser_d = '0;
  logic       req = 1'b0;
  logic       req_we = 1'b0;
  logic       req_ch = 1'b0;
  logic [1:0] req_reg = '0;
  logic [7:0] req_wdata = '0;
  logic       busy;
  logic       ack;
  logic [7:0] rdata;
  logic [7:0] tap_q;
  logic [1:0] phase;
  logic [2:0] bitidx;

  int nchk  = 0;
  int npass = 0;
  int nfail = 0;
  int rcnt  = 0;
  int cyc   = 0;
  int lat;
  int w;
  logic [7:0] rd;
  logic [7:0] pat;

  delay_line_bank #(
    .CHANNELS (CH),
    .PHASES   (PH),
    .WORD     (WD)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .run       (run),
    .ser_we    (ser_we),
    .ser_d     (ser_d),
    .req       (req),
    .req_we    (req_we),
    .req_ch    (req_ch),
    .req_reg   (req_reg),
    .req_wdata (req_wdata),
    .busy      (busy),
    .ack       (ack),
    .rdata     (rdata),
    .tap_q     (tap_q),
    .phase     (phase),
    .bitidx    (bitidx)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nchk++;
    assert (obs === exp) npass++;
    else begin
      nfail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock; rcnt counts the run edges that advance the slot counters.
  task automatic step();
    if (run && !rst) rcnt++;
    @(posedge clk);
    #1;
  endtask

  task automatic check_slot(input string tag);
    check({tag, "_phase"}, 32'(phase), 32'(rcnt % PH));
    check({tag, "_bitidx"}, 32'(bitidx), 32'((rcnt / PH) % WD));
  endtask

  function automatic int exp_wait(input int s0, input int rg);
    for (int k = 0; k < LEN; k++)
      if (((s0 + 1 + k) % LEN) == rg) return k;
    return -1;
  endfunction

  // Issue one access; cyc counts cycles after the accept edge (ack cycle on return).
  task automatic access(input logic we, input logic ch, input logic [1:0] rg,
                        input logic [7:0] wd, input int drop_off, input int rst_off,
                        output logic [7:0] rdo, output int lato, output int wo);
    int drop_at;
    int rst_at;
    wo      = exp_wait(rcnt % LEN, int'(rg));
    drop_at = (drop_off >= 0) ? wo + drop_off : -100;
    rst_at  = (rst_off >= 0) ? wo + rst_off : -100;
    req = 1'b1; req_we = we; req_ch = ch; req_reg = rg; req_wdata = wd;
    step();
    req = 1'b0;
    cyc  = 1;
    lato = -1;
    rdo  = 'x;
    while (cyc <= 100) begin
      if (ack) begin
        lato = cyc;
        rdo  = rdata;
        break;
      end
      if (cyc == drop_at) run = 1'b0;
      if (cyc == drop_at + 10) run = 1'b1;
      if (cyc == rst_at) begin
        rst  = 1'b1;
        rcnt = 0;
      end
      if (cyc == rst_at + 1) begin
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_rdata", 32'(rdata), 32'd0);
        check("rst_tap", 32'(tap_q), 32'd0);
      end
      if (cyc == rst_at + 2) rst = 1'b0;
      step();
      cyc++;
    end
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_ack", 32'(ack), 32'd0);
    check("reset_rdata", 32'(rdata), 32'd0);
    check("reset_tap", 32'(tap_q), 32'd0);
    rst = 1'b0;
    rcnt = 0;
    run = 1'b1;
    check_slot("release");

    // A full traversal of zeroed lines leaves every latch at 0 and the slot at (0,0).
    repeat (LEN) step();
    check("zero_lines_tap", 32'(tap_q), 32'd0);
    check_slot("full_turn");

    // Write ch1/reg2 = A5 from slot (0,0): ack at cycle 31, old contents 0.
    access(1'b1, 1'b1, 2'd2, 8'hA5, -1, -1, rd, lat, w);
    check("wr1_wait", 32'(w), 32'd1);
    check("wr1_latency", 32'(lat), 32'd31);
    check("wr1_rdata", 32'(rd), 32'h00);
    step(); cyc++;
    check("wr1_ack_pulse", 32'(ack), 32'd0);
    check("wr1_busy_drop", 32'(busy), 32'd0);
    while (cyc < 34) begin step(); cyc++; end
    check("tap_c34", 32'(tap_q), 32'h00);
    step(); cyc++;
    pat = 8'hA5;
    for (int b = 0; b < WD; b++) begin
      check($sformatf("tap_bit%0d", b), 32'(tap_q), pat[b] ? 32'h40 : 32'h00);
      repeat (4) begin step(); cyc++; end
    end
    check_slot("after_tap");

    // Two reads return A5 without disturbing it.
    access(1'b0, 1'b1, 2'd2, 8'h00, -1, -1, rd, lat, w);
    check("rd1_latency", 32'(lat), 32'(w + 30));
    check("rd1_rdata", 32'(rd), 32'hA5);
    step();
    access(1'b0, 1'b1, 2'd2, 8'h00, -1, -1, rd, lat, w);
    check("rd2_latency", 32'(lat), 32'(w + 30));
    check("rd2_rdata", 32'(rd), 32'hA5);
    step();

    // Preload ch0/reg0 = FF, then write ch1/reg0 = 5A while both channels inject 0.
    access(1'b1, 1'b0, 2'd0, 8'hFF, -1, -1, rd, lat, w);
    check("wr_ch0_rdata", 32'(rd), 32'h00);
    step();
    ser_we = 2'b11;
    ser_d  = 2'b00;
    access(1'b1, 1'b1, 2'd0, 8'h5A, -1, -1, rd, lat, w);
    check("prio_latency", 32'(lat), 32'(w + 30));
    check("prio_rdata", 32'(rd), 32'h00);
    while (cyc < 33) begin step(); cyc++; end
    ser_we = 2'b00;
    step();
    access(1'b0, 1'b1, 2'd0, 8'h00, -1, -1, rd, lat, w);
    check("prio_fsm_wins", 32'(rd), 32'h5A);
    step();
    access(1'b0, 1'b0, 2'd0, 8'h00, -1, -1, rd, lat, w);
    check("prio_ch0_cleared", 32'(rd), 32'h00);
    step();
    access(1'b0, 1'b1, 2'd2, 8'h00, -1, -1, rd, lat, w);
    check("prio_ch1_reg2_cleared", 32'(rd), 32'h00);
    step();

    // Run dropped for 10 cycles mid-transfer stretches the access by exactly 10.
    access(1'b1, 1'b0, 2'd1, 8'h96, 10, -1, rd, lat, w);
    check("stall_latency", 32'(lat), 32'(w + 40));
    check("stall_rdata", 32'(rd), 32'h00);
    check_slot("after_stall");
    step();
    access(1'b0, 1'b0, 2'd1, 8'h00, -1, -1, rd, lat, w);
    check("stall_readback", 32'(rd), 32'h96);
    step();

    // Reset in the middle of a transfer: no ack, everything cleared.
    access(1'b1, 1'b0, 2'd1, 8'hFF, -1, 15, rd, lat, w);
    check("rst_no_ack", 32'(lat), 32'hFFFF_FFFF);
    check_slot("after_rst");
    access(1'b0, 1'b0, 2'd1, 8'h00, -1, -1, rd, lat, w);
    check("rst_readback", 32'(rd), 32'h00);
    step();
    access(1'b0, 1'b1, 2'd0, 8'h00, -1, -1, rd, lat, w);
    check("rst_readback_ch1", 32'(rd), 32'h00);

    $display("%0d/%0d checks passed", npass, nchk);
    $finish;
  end

endmodule

`default_nettype wire
